// File: rtl/rv32i_types.sv
// rv32i_types
// Shared type and constant package for the memory-side blocks.
// Holds the default cache-line and burst widths and the state encoding
// used by the cacheline adaptor FSM.
// No ports (package only).

package rv32i_types;

  // Default cache line width in bits (32 bytes).
  localparam int CACHE_LINE_WIDTH  = 256;

  // Default physical bus beat width in bits.
  localparam int CACHE_BURST_WIDTH = 64;

  // Cacheline adaptor FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } adaptor_state_t;

endpackage : rv32i_types

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Converts single-cycle cache line requests into multi-beat bursts on the
// physical memory bus. A line fill is assembled beat by beat (beat 0 in the
// LSBs); a writeback line is captured on acceptance and streamed out one
// beat per burst_resp. Completion is signalled with a one-cycle line_resp.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   line_read         cache line fill request (held until line_resp)
//   line_write        cache line writeback request (held until line_resp)
//   line_address      byte address of the line
//   line_wdata        line to write back
//   line_rdata        assembled fill line (holds until the next fill)
//   line_resp         one-cycle completion pulse
//   rd_count/wr_count completed fill/writeback counters (stats build only)
//   burst_address     line-aligned burst address
//   burst_read/write  burst request strobes
//   burst_wdata       current write beat
//   burst_rdata       current read beat
//   burst_resp        beat transferred this cycle
//
// Build option: define CACHELINE_ADAPTOR_STATS_EN to add rd_count/wr_count.

module cacheline_adaptor
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH  = CACHE_LINE_WIDTH,
  parameter int BURST_WIDTH = CACHE_BURST_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   line_read,
  input  logic                   line_write,
  input  logic [31:0]            line_address,
  input  logic [LINE_WIDTH-1:0]  line_wdata,
  output logic [LINE_WIDTH-1:0]  line_rdata,
  output logic                   line_resp,
`ifdef CACHELINE_ADAPTOR_STATS_EN
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count,
`endif

  output logic [31:0]            burst_address,
  output logic                   burst_read,
  output logic                   burst_write,
  output logic [BURST_WIDTH-1:0] burst_wdata,
  input  logic [BURST_WIDTH-1:0] burst_rdata,
  input  logic                   burst_resp
);

  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

  adaptor_state_t        state;
  logic [BEAT_BITS-1:0]  beat;
  logic [LINE_WIDTH-1:0] captured_wdata;
  logic [31:0]           aligned_address;

`ifdef CACHELINE_ADAPTOR_STATS_EN
  // Remembers which burst type is finishing so RESP can bump the right counter.
  logic                  is_write;
`endif

  // The byte offset within the line never reaches the bus; the reduction
  // below only marks those bits as intentionally dropped.
  logic unused_offset_bits;
  assign unused_offset_bits = ^line_address[OFFSET_BITS-1:0];

  assign aligned_address = {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  // Single FSM with all outputs registered. Line inputs are sampled only
  // when leaving IDLE, so anything the cache does to them mid-burst is
  // invisible. burst_resp is only honoured in READ and WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      beat           <= '0;
      captured_wdata <= '0;
      line_rdata     <= '0;
      line_resp      <= 1'b0;
      burst_address  <= '0;
      burst_read     <= 1'b0;
      burst_write    <= 1'b0;
      burst_wdata    <= '0;
`ifdef CACHELINE_ADAPTOR_STATS_EN
      is_write       <= 1'b0;
      rd_count       <= '0;
      wr_count       <= '0;
`endif
    end else begin
      line_resp <= 1'b0;

      case (state)
        IDLE: begin
          // Writeback has priority so a dirty victim leaves before the fill.
          if (line_write) begin
            state          <= WRITE;
            beat           <= '0;
            captured_wdata <= line_wdata;
            burst_address  <= aligned_address;
            burst_write    <= 1'b1;
            burst_wdata    <= line_wdata[BURST_WIDTH-1:0];
`ifdef CACHELINE_ADAPTOR_STATS_EN
            is_write       <= 1'b1;
`endif
          end else if (line_read) begin
            state          <= READ;
            beat           <= '0;
            captured_wdata <= line_wdata;
            burst_address  <= aligned_address;
            burst_read     <= 1'b1;
`ifdef CACHELINE_ADAPTOR_STATS_EN
            is_write       <= 1'b0;
`endif
          end
        end

        READ: begin
          if (burst_resp) begin
            line_rdata[int'(beat)*BURST_WIDTH +: BURST_WIDTH] <= burst_rdata;
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state      <= RESP;
              burst_read <= 1'b0;
              line_resp  <= 1'b1;
            end
          end
        end

        WRITE: begin
          // burst_wdata is preloaded with the next beat so it is already
          // valid in the cycle after each accepted beat.
          if (burst_resp) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state       <= RESP;
              burst_write <= 1'b0;
              burst_wdata <= '0;
              line_resp   <= 1'b1;
            end else begin
              burst_wdata <= captured_wdata[(int'(beat) + 1)*BURST_WIDTH +: BURST_WIDTH];
            end
          end
        end

        RESP: begin
          state <= IDLE;
`ifdef CACHELINE_ADAPTOR_STATS_EN
          if (is_write) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
// Self-checking bench for cacheline_adaptor. A line-level reference model
// (expected fill line, expected beat stream, expected completion cycle and
// transaction counts) is kept here and compared against the DUT after every
// clock. Directed cases cover fills, writebacks, stalls, request priority,
// held requests and reset mid-burst; a randomized loop follows.
// No ports.

module tb_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_read;
  logic          line_write;
  logic [31:0]   line_address;
  logic [LW-1:0] line_wdata;
  logic [LW-1:0] line_rdata;
  logic          line_resp;
  logic [31:0]   burst_address;
  logic          burst_read;
  logic          burst_write;
  logic [BW-1:0] burst_wdata;
  logic [BW-1:0] burst_rdata;
  logic          burst_resp;
`ifdef CACHELINE_ADAPTOR_STATS_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: the line the cache should currently see and how many
  // fills and writebacks have completed since reset.
  logic [LW-1:0] model_rdata;
  int            model_rd;
  int            model_wr;

  always #5 clk = ~clk;

  cacheline_adaptor #(
    .LINE_WIDTH  (LW),
    .BURST_WIDTH (BW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
`ifdef CACHELINE_ADAPTOR_STATS_EN
    .rd_count      (rd_count),
    .wr_count      (wr_count),
`endif
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  // Single comparison point: counts every check, reports any difference.
  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] random_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Checks that hold in every cycle of an active burst.
  task automatic check_active(input bit is_wr, input logic [31:0] exp_addr,
                              input logic [LW-1:0] wdata, input int idx);
    checkOutput("burst_read_active",  burst_read,  !is_wr);
    checkOutput("burst_write_active", burst_write, is_wr);
    checkOutput("burst_address",      burst_address, exp_addr);
    checkOutput("line_resp_early",    line_resp, 1'b0);
    if (is_wr) checkOutput("burst_wdata", burst_wdata, wdata[idx*BW +: BW]);
  endtask

  // Runs one complete line transaction. stall < 0 picks 0..3 idle cycles
  // per beat at random, otherwise exactly stall idle cycles per beat.
  // fixed_beats uses the 0x11../0x22../.. pattern for read data.
  task automatic applyStimulus(input bit do_read, input bit do_write,
                               input logic [31:0] addr, input logic [LW-1:0] wdata,
                               input int stall, input bit fixed_beats,
                               input bit hold_req);
    logic [BW-1:0] beat_data [NB];
    logic [31:0]   exp_addr;
    bit            is_wr;
    int            n_stall;

    is_wr    = do_write;
    exp_addr = addr & 32'hFFFF_FFE0;

    line_read    = do_read;
    line_write   = do_write;
    line_address = addr;
    line_wdata   = wdata;
    burst_resp   = 1'b0;
    step();

    // The adaptor must ignore anything the cache does to these now.
    line_address = $urandom;
    line_wdata   = random_line();

    for (int i = 0; i < NB; i++) begin
      n_stall = (stall < 0) ? int'($urandom_range(3, 0)) : stall;
      for (int s = 0; s < n_stall; s++) begin
        burst_resp  = 1'b0;
        burst_rdata = {$urandom, $urandom};
        check_active(is_wr, exp_addr, wdata, i);
        step();
      end
      beat_data[i] = fixed_beats ? 64'h1111_1111_1111_1111 * 64'(i + 1)
                                 : {$urandom, $urandom};
      burst_rdata  = beat_data[i];
      burst_resp   = 1'b1;
      check_active(is_wr, exp_addr, wdata, i);
      step();
    end

    if (is_wr) begin
      model_wr++;
    end else begin
      model_rd++;
      for (int i = 0; i < NB; i++) model_rdata[i*BW +: BW] = beat_data[i];
    end

    // Completion cycle: a stray beat here must be ignored.
    burst_resp  = 1'b1;
    burst_rdata = {$urandom, $urandom};
    checkOutput("line_resp",        line_resp,   1'b1);
    checkOutput("burst_read_resp",  burst_read,  1'b0);
    checkOutput("burst_write_resp", burst_write, 1'b0);
    checkOutput("line_rdata_resp",  line_rdata,  model_rdata);
    if (!hold_req) begin
      line_read  = 1'b0;
      line_write = 1'b0;
    end
    step();

    // Back in idle; stray beats still ignored.
    burst_rdata = {$urandom, $urandom};
    checkOutput("line_resp_pulse",  line_resp,   1'b0);
    checkOutput("burst_read_idle",  burst_read,  1'b0);
    checkOutput("burst_write_idle", burst_write, 1'b0);
    checkOutput("line_rdata_idle",  line_rdata,  model_rdata);
    if (!hold_req) begin
      step();
      checkOutput("idle_stays",       burst_read | burst_write | line_resp, 1'b0);
      checkOutput("line_rdata_stray", line_rdata, model_rdata);
    end
    burst_resp = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_line_resp"},     line_resp,     1'b0);
    checkOutput({tag, "_burst_read"},    burst_read,    1'b0);
    checkOutput({tag, "_burst_write"},   burst_write,   1'b0);
    checkOutput({tag, "_burst_address"}, burst_address, 32'h0);
    checkOutput({tag, "_burst_wdata"},   burst_wdata,   64'h0);
    checkOutput({tag, "_line_rdata"},    line_rdata,    {LW{1'b0}});
`ifdef CACHELINE_ADAPTOR_STATS_EN
    checkOutput({tag, "_rd_count"},      rd_count,      32'h0);
    checkOutput({tag, "_wr_count"},      wr_count,      32'h0);
`endif
  endtask

  logic [LW-1:0] wline;
  logic [LW-1:0] prev_line;

  initial begin
    rst_n        = 1'b0;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    model_rdata  = '0;
    model_rd     = 0;
    model_wr     = 0;

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Line fill with the reference beat pattern.
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, '0, 0, 1'b1, 1'b0);
    checkOutput("fill_pattern", line_rdata,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Writeback streams D0..D3 in order; fill line untouched.
    wline = {64'hD3D3_0000_0000_00D3, 64'hD2D2_0000_0000_00D2,
             64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0};
    prev_line = model_rdata;
    applyStimulus(1'b0, 1'b1, 32'hABCD_EF1F, wline, 0, 1'b0, 1'b0);
    checkOutput("write_keeps_rdata", line_rdata, prev_line);

    // Two idle cycles between every beat.
    applyStimulus(1'b1, 1'b0, 32'h8000_0040, '0, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_00FF, random_line(), 2, 1'b0, 1'b0);

    // Simultaneous read and write: write wins, fill line unchanged.
    prev_line = model_rdata;
    applyStimulus(1'b1, 1'b1, 32'h1234_5678, random_line(), -1, 1'b0, 1'b0);
    checkOutput("both_keeps_rdata", line_rdata, prev_line);

    // Request held through completion is taken again straight away.
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, '0, 0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, '0, 0, 1'b0, 1'b0);

    // Reset after two beats of a read aborts it.
    line_read    = 1'b1;
    line_address = 32'h0000_3000;
    step();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b0;
    #2;
    model_rdata = '0;
    model_rd    = 0;
    model_wr    = 0;
    check_reset_outputs("abort");
    line_read  = 1'b0;
    burst_resp = 1'b0;
    step();
    checkOutput("abort_no_resp", line_resp, 1'b0);
    rst_n = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 32'h0000_3000, '0, 0, 1'b0, 1'b0);

    // Randomized mix of fills and writebacks.
    for (int t = 0; t < 30; t++) begin
      int kind;
      kind = int'($urandom_range(2, 0));
      applyStimulus(kind != 1, kind != 0, $urandom, random_line(), -1, 1'b0,
                    ($urandom_range(3, 0) == 0));
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    step();
    step();

`ifdef CACHELINE_ADAPTOR_STATS_EN
    checkOutput("rd_count", rd_count, 32'(model_rd));
    checkOutput("wr_count", wr_count, 32'(model_wr));
`endif
    checkOutput("final_rdata", line_rdata, model_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cacheline_adaptor
